// File: rtl/dm_wb_cache_ctrl.sv
// rtl/dm_wb_cache_ctrl.sv - direct-mapped write-back write-allocate data cache controller
module dm_wb_cache_ctrl #(
   parameter int LINES     = 256,
   parameter int LINE_BITS = 128,
   parameter int ADDR_W    = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 read_req,
   input  logic                 write_req,
   input  logic                 cache_flush,
   input  logic [ADDR_W-1:0]    p_addr,
   input  logic [31:0]          p_w_data,
   output logic [31:0]          p_r_data,
   output logic [ADDR_W-1:0]    m_addr,
   output logic [LINE_BITS-1:0] m_w_data,
   input  logic [LINE_BITS-1:0] m_r_data,
   input  logic                 main_mem_ack,
   output logic                 mem_write,
   output logic                 mem_read,
   output logic                 stall
);
   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = ADDR_W - IDX_W - 4;

   typedef enum logic [2:0] {IDLE, COMPARE, WRITE_BACK, ALLOCATE, FLUSH} state_t;
   state_t state, next_state;

   logic [TAG_W-1:0]     tag_arr  [LINES];
   logic [LINE_BITS-1:0] data_arr [LINES];
   logic [LINES-1:0]     valid, dirty;

   logic [ADDR_W-1:2] req_addr;
   logic [31:0]       req_data;
   logic              req_write;
   logic              flushing;
   logic [IDX_W-1:0]  flush_ptr;

   logic [TAG_W-1:0] req_tag;
   logic [IDX_W-1:0] req_idx, wb_idx;
   logic [1:0]       req_word;
   logic             hit, flush_dirty, flush_last;
   logic             unused_addr_bits;

   assign unused_addr_bits = ^p_addr[1:0];
   assign req_tag     = req_addr[ADDR_W-1 -: TAG_W];
   assign req_idx     = req_addr[IDX_W+3:4];
   assign req_word    = req_addr[3:2];
   assign wb_idx      = flushing ? flush_ptr : req_idx;
   assign hit         = valid[req_idx] && (tag_arr[req_idx] == req_tag);
   assign flush_dirty = valid[flush_ptr] && dirty[flush_ptr];
   assign flush_last  = (flush_ptr == IDX_W'(LINES - 1));
   assign stall       = (state != IDLE) || read_req || write_req || cache_flush;

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (cache_flush)                next_state = FLUSH;
            else if (write_req || read_req) next_state = COMPARE;
         end
         COMPARE: begin
            if (hit)                                    next_state = IDLE;
            else if (valid[req_idx] && dirty[req_idx])  next_state = WRITE_BACK;
            else                                        next_state = ALLOCATE;
         end
         WRITE_BACK: begin
            if (main_mem_ack) begin
               if (!flushing)       next_state = ALLOCATE;
               else if (flush_last) next_state = IDLE;
               else                 next_state = FLUSH;
            end
         end
         ALLOCATE: if (main_mem_ack) next_state = COMPARE;
         FLUSH: begin
            if (flush_dirty)     next_state = WRITE_BACK;
            else if (flush_last) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         valid     <= '0;
         dirty     <= '0;
         req_addr  <= '0;
         req_data  <= '0;
         req_write <= 1'b0;
         flushing  <= 1'b0;
         flush_ptr <= '0;
         p_r_data  <= '0;
         m_addr    <= '0;
         m_w_data  <= '0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
      end else begin
         state <= next_state;
         case (state)
            IDLE: begin
               flushing <= cache_flush;
               if (cache_flush) begin
                  flush_ptr <= '0;
               end else if (write_req || read_req) begin
                  req_addr  <= p_addr[ADDR_W-1:2];
                  req_data  <= p_w_data;
                  req_write <= write_req;
               end
            end
            COMPARE: begin
               if (hit && req_write)  dirty[req_idx] <= 1'b1;
               else if (hit)          p_r_data <= data_arr[req_idx][{req_word, 5'd0} +: 32];
            end
            WRITE_BACK: begin
               if (main_mem_ack) begin
                  dirty[wb_idx] <= 1'b0;
                  if (flushing && !flush_last) flush_ptr <= flush_ptr + 1'b1;
               end
            end
            ALLOCATE: begin
               if (main_mem_ack) begin
                  valid[req_idx] <= 1'b1;
                  dirty[req_idx] <= 1'b0;
               end
            end
            FLUSH: if (!flush_dirty && !flush_last) flush_ptr <= flush_ptr + 1'b1;
            default: ;
         endcase
         // Strobes and line address are registered from the upcoming state so they appear with it.
         mem_write <= (next_state == WRITE_BACK);
         mem_read  <= (next_state == ALLOCATE);
         if (next_state == WRITE_BACK) begin
            m_addr   <= {tag_arr[wb_idx], wb_idx, 4'h0};
            m_w_data <= data_arr[wb_idx];
         end else if (next_state == ALLOCATE) begin
            m_addr <= {req_tag, req_idx, 4'h0};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (state == ALLOCATE && main_mem_ack) begin
         data_arr[req_idx] <= m_r_data;
         tag_arr[req_idx]  <= req_tag;
      end else if (state == COMPARE && hit && req_write) begin
         data_arr[req_idx][{req_word, 5'd0} +: 32] <= req_data;
      end
   end
endmodule

// File: tb/tb_dm_wb_cache_ctrl.sv
// tb/tb_dm_wb_cache_ctrl.sv - self-checking bench for dm_wb_cache_ctrl against a processor-view model
module tb_dm_wb_cache_ctrl;
   logic         clk = 1'b0;
   logic         rst_n, read_req, write_req, cache_flush, main_mem_ack;
   logic [31:0]  p_addr, p_w_data, p_r_data, m_addr;
   logic [127:0] m_w_data, m_r_data;
   logic         mem_write, mem_read, stall;

   always #5 clk = ~clk;

   dm_wb_cache_ctrl dut (
      .clk(clk), .rst_n(rst_n), .read_req(read_req), .write_req(write_req),
      .cache_flush(cache_flush), .p_addr(p_addr), .p_w_data(p_w_data), .p_r_data(p_r_data),
      .m_addr(m_addr), .m_w_data(m_w_data), .m_r_data(m_r_data), .main_mem_ack(main_mem_ack),
      .mem_write(mem_write), .mem_read(mem_read), .stall(stall)
   );

   typedef struct {bit wr; logic [31:0] addr; logic [127:0] data;} xfer_t;
   xfer_t log_q[$];
   xfer_t exp_q[$];
   logic [127:0] mm_mem    [logic [31:0]];
   logic [127:0] model_mem [logic [31:0]];
   logic [31:0]  pview     [logic [31:0]];
   bit [19:0]    m_tag   [256];
   bit           m_valid [256];
   bit           m_dirty [256];
   int checks = 0, failures = 0, both_cnt = 0;

   // Memory model: one-cycle ack after a strobe is seen; written lines are kept and returned on reads.
   always @(posedge clk) begin
      #1;
      if (mem_read && mem_write) both_cnt++;
      if (main_mem_ack) main_mem_ack = 1'b0;
      else if (mem_read || mem_write) begin
         log_q.push_back('{mem_write, m_addr, mem_write ? m_w_data : 128'h0});
         if (mem_write) mm_mem[m_addr] = m_w_data;
         else m_r_data = mm_mem.exists(m_addr) ? mm_mem[m_addr] : {4{m_addr}};
         main_mem_ack = 1'b1;
      end
   end

   task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] word_of(logic [31:0] a);
      logic [31:0]  wa = {a[31:2], 2'b00};
      logic [31:0]  la = {a[31:4], 4'h0};
      logic [127:0] ln;
      if (pview.exists(wa)) return pview[wa];
      if (model_mem.exists(la)) begin
         ln = model_mem[la];
         return ln[{a[3:2], 5'd0} +: 32];
      end
      return la;
   endfunction

   function automatic logic [127:0] line_of(logic [31:0] la);
      return {word_of(la + 32'd12), word_of(la + 32'd8), word_of(la + 32'd4), word_of(la)};
   endfunction

   task automatic compare_traffic(string tag);
      check($sformatf("%s_xfer_count", tag), 128'(log_q.size()), 128'(exp_q.size()));
      for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
         check($sformatf("%s_xfer%0d_wr", tag, i), 128'(log_q[i].wr), 128'(exp_q[i].wr));
         check($sformatf("%s_xfer%0d_addr", tag, i), 128'(log_q[i].addr), 128'(exp_q[i].addr));
         if (exp_q[i].wr)
            check($sformatf("%s_xfer%0d_data", tag, i), log_q[i].data, exp_q[i].data);
      end
   endtask

   task automatic do_access(bit wr, logic [31:0] a, logic [31:0] d, string tag);
      int          idx = int'(a[11:4]);
      logic [31:0] old;
      logic [127:0] ln;
      int          exp_cyc, cyc;
      exp_q.delete();
      if (m_valid[idx] && m_tag[idx] == a[31:12]) exp_cyc = 1;
      else begin
         exp_cyc = 3;
         if (m_valid[idx] && m_dirty[idx]) begin
            old = {m_tag[idx], a[11:4], 4'h0};
            ln  = line_of(old);
            exp_q.push_back('{1'b1, old, ln});
            model_mem[old] = ln;
            exp_cyc = 5;
         end
         exp_q.push_back('{1'b0, {a[31:4], 4'h0}, 128'h0});
         m_tag[idx]   = a[31:12];
         m_valid[idx] = 1'b1;
         m_dirty[idx] = 1'b0;
      end
      if (wr) begin
         m_dirty[idx] = 1'b1;
         pview[{a[31:2], 2'b00}] = d;
      end
      @(negedge clk);
      log_q.delete();
      write_req = wr;
      read_req  = !wr;
      p_addr    = a;
      p_w_data  = d;
      #1 check($sformatf("%s_stall_on_req", tag), 128'(stall), 128'(1));
      @(posedge clk);
      #1 read_req = 1'b0;
      write_req = 1'b0;
      cyc = 0;
      do begin
         @(negedge clk);
         if (stall) cyc++;
      end while (stall && cyc < 100);
      check($sformatf("%s_stall_cycles", tag), 128'(cyc), 128'(exp_cyc));
      if (!wr) check($sformatf("%s_rdata", tag), 128'(p_r_data), 128'(word_of(a)));
      compare_traffic(tag);
   endtask

   task automatic do_flush(string tag);
      logic [31:0]  old;
      logic [127:0] ln;
      int cyc;
      exp_q.delete();
      for (int i = 0; i < 256; i++) begin
         if (m_valid[i] && m_dirty[i]) begin
            old = {m_tag[i], 8'(i), 4'h0};
            ln  = line_of(old);
            exp_q.push_back('{1'b1, old, ln});
            model_mem[old] = ln;
            m_dirty[i] = 1'b0;
         end
      end
      @(negedge clk);
      log_q.delete();
      cache_flush = 1'b1;
      #1 check($sformatf("%s_stall_on_req", tag), 128'(stall), 128'(1));
      @(posedge clk);
      #1 cache_flush = 1'b0;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (stall && cyc < 3000);
      check($sformatf("%s_done", tag), 128'(stall), 128'(0));
      compare_traffic(tag);
   endtask

   logic [19:0] rnd_tags [4] = '{20'h12345, 20'h0BEEF, 20'h7A5A5, 20'hABCD0};

   initial begin
      rst_n = 1'b0; read_req = 1'b0; write_req = 1'b0; cache_flush = 1'b0;
      p_addr = '0; p_w_data = '0; main_mem_ack = 1'b0; m_r_data = '0;
      #12;
      check("rst_p_r_data", 128'(p_r_data), 128'(0));
      check("rst_m_addr", 128'(m_addr), 128'(0));
      check("rst_m_w_data", m_w_data, 128'(0));
      check("rst_mem_read", 128'(mem_read), 128'(0));
      check("rst_mem_write", 128'(mem_write), 128'(0));
      check("rst_stall", 128'(stall), 128'(0));
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 5; i++)
         do_access(1'b1, 32'hABCD_0000 + 32'(i * 16), 32'hABCD_EF01, $sformatf("wr_miss%0d", i));
      do_access(1'b0, 32'hABCD_FF01, 32'h0, "rd_ff01");
      check("rd_ff01_const", 128'(p_r_data), 128'(32'hABCD_FF00));
      do_access(1'b1, 32'hABCD_0000, 32'hABCD_EF01, "wr_hit_a");
      do_access(1'b1, 32'hABCD_0000, 32'hABCD_EF01, "wr_hit_b");
      do_access(1'b1, 32'hABCD_0FF0, 32'hABCD_EF01, "wr_idx255");
      do_access(1'b0, 32'h2AF3_4000, 32'h0, "rd_conflict");
      check("rd_conflict_const", 128'(p_r_data), 128'(32'h2AF3_4000));
      do_flush("flush1");
      check("flush1_writes", 128'(log_q.size()), 128'(5));
      do_flush("flush2");
      check("flush2_writes", 128'(log_q.size()), 128'(0));

      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 19) == 0) do_flush($sformatf("rflush%0d", n));
         else do_access(1'($urandom_range(0, 1)),
                        {rnd_tags[$urandom_range(0, 3)], 8'($urandom_range(0, 5)), 4'($urandom_range(0, 15))},
                        $urandom, $sformatf("rnd%0d", n));
      end
      do_flush("flush_end");

      @(negedge clk);
      read_req = 1'b1;
      p_addr   = 32'h5555_0120;
      @(posedge clk);
      #1 read_req = 1'b0;
      for (int i = 0; i < 20 && !mem_read; i++) @(negedge clk);
      check("alloc_mem_read", 128'(mem_read), 128'(1));
      rst_n = 1'b0;
      #1;
      check("async_rst_mem_read", 128'(mem_read), 128'(0));
      check("async_rst_mem_write", 128'(mem_write), 128'(0));
      check("async_rst_stall", 128'(stall), 128'(0));
      for (int i = 0; i < 256; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
      end
      @(negedge clk);
      rst_n = 1'b1;
      do_access(1'b0, 32'h5555_0120, 32'h0, "rd_after_rst");
      check("strobes_exclusive", 128'(both_cnt), 128'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/dm_wb_cache_ctrl.md
Name: dm_wb_cache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache controller between a 32-bit processor port and a 128-bit-line main memory port.
- Holds tag, valid, dirty and data arrays internally.
- Stalls the processor on misses and flushes, and runs a request/acknowledge handshake with an external memory model.

Parameters:
- LINES, 256, number of cache lines. Index width is log2(LINES) = 8.
- LINE_BITS, 128, line width: 4 words of 32 bits, 16 bytes.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- read_req  in  1  processor read request (level).
- write_req  in  1  processor write request (level).
- cache_flush  in  1  request write-back of all dirty lines.
- p_addr  in  32  processor byte address.
- p_w_data  in  32  processor write word.
- p_r_data  out  32  processor read word.
- m_addr  out  32  memory line address, always 16-byte aligned (bits [3:0]=0).
- m_w_data  out  128  line sent to memory on write-back.
- m_r_data  in  128  line returned by memory.
- main_mem_ack  in  1  memory completion pulse for the current mem_read/mem_write.
- mem_write  out  1  memory write strobe.
- mem_read  out  1  memory read strobe.
- stall  out  1  processor must hold/wait.

Behaviour:
- Address split: tag = p_addr[31:12] (20 bits), index = p_addr[11:4], word = p_addr[3:2]. Bits [1:0] are ignored.
- Reset (rst_n=0, asynchronous): state=IDLE; all valid and dirty bits cleared; p_r_data, m_addr, m_w_data, mem_read, mem_write and stall are 0. Data and tag arrays need no reset. Reset mid-transaction aborts it with no memory write.
- stall is 1 in every state except IDLE. It is also 1 combinationally in IDLE while any request is present, and it drops in the cycle the access completes.
- Priority in IDLE: cache_flush > write_req > read_req. The request, p_addr and p_w_data are captured on the accepting edge; the processor must hold them until stall is 0.
- States:
  - IDLE: on a request, latch address/data and go to COMPARE. On cache_flush, set line pointer = 0 and go to FLUSH.
  - COMPARE: hit = valid[idx] && tag[idx]==tag.
    - Read hit: p_r_data = selected word; go to IDLE.
    - Write hit: write the word, set dirty; go to IDLE.
    - Miss with dirty line: go to WRITE_BACK.
    - Miss otherwise: go to ALLOCATE.
  - WRITE_BACK: mem_write=1, m_addr={old tag, idx, 4'h0}, m_w_data=stored line, all held until main_mem_ack. On ack: mem_write=0, clear dirty, go to ALLOCATE.
  - ALLOCATE: mem_read=1, m_addr={tag, idx, 4'h0}, held until main_mem_ack. On ack: store m_r_data and the tag, set valid, clear dirty, go to COMPARE. The retry then hits, so a write miss merges its word and sets dirty.
  - FLUSH: for each line 0..LINES-1, if valid && dirty, perform the WRITE_BACK handshake and clear dirty; valid stays set. After line LINES-1, go to IDLE.
- mem_read and mem_write are never both 1. Strobes are registered and drop the cycle after ack is sampled.
- A request still asserted when the FSM returns to IDLE is treated as a new request. Repeating a hit is idempotent.
- Requests arriving while not in IDLE are ignored.
- Minimum latencies:
  - Hit: 2 cycles accept-to-IDLE.
  - Clean miss: 2 + memory latency + 1 cycles.
  - Dirty miss: adds one full write-back handshake.
- Word select within the line: word 0 = bits [31:0], word 3 = bits [127:96].

Test Plan:
- Bench memory model returns line = {4{addr}} one cycle after the strobe, with a 1-cycle ack; writes are stored.
- Write 0xABCD_EF01 to 0xABCD_0000, 0xABCD_0010..0xABCD_0040 (5 clean misses) -> mem_read with m_addr matching each address and no mem_write. Lines 0..4 become valid and dirty, with word0 = 0xABCD_EF01. stall=1 until each completes.
- Read 0xABCD_FF01 (index 0xF0, invalid) -> mem_read at m_addr 0xABCD_FF00; p_r_data = 0xABCD_FF00 (word 0); no mem_write.
- Write 0xABCD_0000 twice -> both hits; no mem_read/mem_write; stall high for exactly one cycle after accept. Then write 0xABCD_0FF0 -> miss to index 255 at m_addr 0xABCD_0FF0; word 0 = 0xABCD_EF01.
- Read 0x2AF3_4000 (index 0, conflict with dirty tag 0xABCD0) -> mem_write with m_addr 0xABCD_0000 and m_w_data[31:0] = 0xABCD_EF01; then mem_read at 0x2AF3_4000; p_r_data = 0x2AF3_4000.
- Assert cache_flush -> one mem_write per remaining dirty line (indices 1,2,3,4,255 in ascending order), then stall=0. A second flush produces no memory traffic.
- Drive rst_n low during an ALLOCATE -> mem_read=0 and stall=0 immediately (asynchronously). A following read of the old address misses.
